// File: rtl/stack_mem_io_if.sv
// rtl/stack_mem_io_if.sv - processor-side bus between the stack core and its memory
interface stack_mem_io_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              req;
  logic              readwriteN;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              ack;
  logic              err;
  logic              busy;

  modport master (
    output req, readwriteN, address, data_in,
    input  data_out, ack, err, busy
  );

  modport slave (
    input  req, readwriteN, address, data_in,
    output data_out, ack, err, busy
  );
endinterface

// File: rtl/stack_mem_io.sv
// rtl/stack_mem_io.sv - stack processor RAM with memory-mapped I/O window at the top of the map
// RAM is zeroed by a hardware sweep after every reset; ports sit at IO_BASE..2^ADDR_W-1.
module stack_mem_io #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int N_IN   = 7,
  parameter int N_OUT  = 1
) (
  input  logic                    clk,
  input  logic                    resetN,
  stack_mem_io_if.slave           bus,
  input  logic [N_IN*DATA_W-1:0]  indata,
  output logic [N_OUT*DATA_W-1:0] outdata,
  output logic [N_OUT-1:0]        out_strobe
);

  localparam int IO_BASE = 2**ADDR_W - N_IN - N_OUT;
  localparam int RAM_AW  = $clog2(IO_BASE);
  localparam logic [ADDR_W-1:0] IO_BASE_A = ADDR_W'(IO_BASE);
  localparam logic [ADDR_W-1:0] IN_BASE_A = ADDR_W'(IO_BASE + N_OUT);
  localparam logic [RAM_AW-1:0] LAST_PTR  = RAM_AW'(IO_BASE - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state_q, state_d;
  logic [RAM_AW-1:0] ptr_q;

  logic [DATA_W-1:0] mem   [IO_BASE];
  logic [DATA_W-1:0] in_q  [N_IN];
  logic [DATA_W-1:0] out_q [N_OUT];

  logic              accept;
  logic              illegal;
  logic              is_ram;
  logic              is_out;
  logic [ADDR_W-1:0] off_out;
  logic [ADDR_W-1:0] off_in;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_wa;
  logic [DATA_W-1:0] ram_wd;
  logic [N_OUT-1:0]  out_we;
  logic [DATA_W-1:0] rd_data;

  // State register; the clear pointer only advances while sweeping
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR)
        ptr_q <= ptr_q + RAM_AW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == CLEAR && ptr_q == LAST_PTR)
      state_d = IDLE;
  end

  always_comb begin
    accept  = 1'b0;
    illegal = 1'b0;
    ram_we  = 1'b0;
    ram_wa  = '0;
    ram_wd  = '0;
    out_we  = '0;
    rd_data = '0;
    is_ram  = (bus.address < IO_BASE_A);
    is_out  = !is_ram && (bus.address < IN_BASE_A);
    off_out = bus.address - IO_BASE_A;
    off_in  = bus.address - IN_BASE_A;

    if (resetN) begin
      if (state_q == CLEAR) begin
        ram_we = 1'b1;
        ram_wa = ptr_q;
      end else if (bus.req) begin
        accept = 1'b1;
        if (!bus.readwriteN) begin
          if (is_ram) begin
            ram_we = 1'b1;
            ram_wa = bus.address[RAM_AW-1:0];
            ram_wd = bus.data_in;
          end else if (is_out) begin
            for (int k = 0; k < N_OUT; k++)
              out_we[k] = (off_out == ADDR_W'(k));
          end else begin
            illegal = 1'b1;
          end
        end
      end
    end

    if (is_ram) begin
      rd_data = mem[bus.address[RAM_AW-1:0]];
    end else if (is_out) begin
      for (int k = 0; k < N_OUT; k++)
        if (off_out == ADDR_W'(k)) rd_data = out_q[k];
    end else begin
      for (int k = 0; k < N_IN; k++)
        if (off_in == ADDR_W'(k)) rd_data = in_q[k];
    end
  end

  assign bus.busy = (state_q == CLEAR);

  always_ff @(posedge clk) begin
    if (ram_we)
      mem[ram_wa] <= ram_wd;
  end

  // Inputs are sampled unconditionally so reads always see a one-edge-old value
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_IN; k++)
      in_q[k] <= indata[k*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      bus.data_out <= '0;
      bus.ack      <= 1'b0;
      bus.err      <= 1'b0;
      out_strobe   <= '0;
      for (int k = 0; k < N_OUT; k++)
        out_q[k] <= '0;
    end else begin
      bus.ack    <= accept;
      bus.err    <= illegal;
      out_strobe <= out_we;
      if (accept && bus.readwriteN)
        bus.data_out <= rd_data;
      for (int k = 0; k < N_OUT; k++)
        if (out_we[k]) out_q[k] <= bus.data_in;
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_out
    assign outdata[g*DATA_W +: DATA_W] = out_q[g];
  end

endmodule

// File: tb/tb_stack_mem_io.sv
// tb/tb_stack_mem_io.sv - directed bench for stack_mem_io, default map and a small 6-bit map
module tb_stack_mem_io;

  logic        clk = 1'b0;
  logic        resetN0, resetN1;
  logic [55:0] indata0;
  logic [7:0]  outdata0;
  logic [0:0]  out_strobe0;
  logic [15:0] indata1;
  logic [23:0] outdata1;
  logic [2:0]  out_strobe1;

  int n_vec = 0;
  int n_bad = 0;
  int n;
  bit saw;

  stack_mem_io_if #(.DATA_W(8), .ADDR_W(8)) b0 ();
  stack_mem_io_if #(.DATA_W(8), .ADDR_W(6)) b1 ();

  stack_mem_io #(.DATA_W(8), .ADDR_W(8), .N_IN(7), .N_OUT(1)) u0 (
    .clk(clk), .resetN(resetN0), .bus(b0),
    .indata(indata0), .outdata(outdata0), .out_strobe(out_strobe0)
  );

  stack_mem_io #(.DATA_W(8), .ADDR_W(6), .N_IN(2), .N_OUT(3)) u1 (
    .clk(clk), .resetN(resetN1), .bus(b1),
    .indata(indata1), .outdata(outdata1), .out_strobe(out_strobe1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one request and leaves req high, so consecutive calls form a burst
  task automatic acc(input int d, input bit rd, input logic [7:0] a, input logic [7:0] wd);
    if (d == 0) begin
      b0.req = 1'b1; b0.readwriteN = rd; b0.address = a; b0.data_in = wd;
    end else begin
      b1.req = 1'b1; b1.readwriteN = rd; b1.address = a[5:0]; b1.data_in = wd;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int d);
    if (d == 0) b0.req = 1'b0;
    else        b1.req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic clear_len(input int d, input int stop_at, output int cnt, output bit any_ack);
    cnt = 0;
    any_ack = 1'b0;
    while (((d == 0) ? b0.busy : b1.busy) && cnt != stop_at && cnt < 400) begin
      @(posedge clk); #1;
      cnt++;
      if ((d == 0) ? b0.ack : b1.ack) any_ack = 1'b1;
    end
  endtask

  task automatic reset0;
    b0.req = 1'b0;
    resetN0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetN0 = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    resetN0 = 1'b0; resetN1 = 1'b0;
    indata0 = '0;   indata1 = '0;
    b0.req = 1'b0; b0.readwriteN = 1'b1; b0.address = '0; b0.data_in = '0;
    b1.req = 1'b0; b1.readwriteN = 1'b1; b1.address = '0; b1.data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", b0.busy, 1);
    check("rst_ack", b0.ack, 0);
    check("rst_err", b0.err, 0);
    check("rst_dout", b0.data_out, 0);
    check("rst_outdata", outdata0, 0);
    check("rst_strobe", out_strobe0, 0);

    resetN0 = 1'b1;
    b0.req = 1'b1; b0.readwriteN = 1'b1; b0.address = 8'h00;
    clear_len(0, -1, n, saw);
    b0.req = 1'b0;
    check("clear_len", n, 248);
    check("clear_no_ack", saw, 0);

    acc(0, 1, 8'h00, 8'h00); check("rd00_ack", b0.ack, 1); check("rd00", b0.data_out, 8'h00);
    acc(0, 1, 8'h7A, 8'h00); check("rd7a", b0.data_out, 8'h00);
    acc(0, 1, 8'hF7, 8'h00); check("rdf7", b0.data_out, 8'h00);
    acc(0, 0, 8'h10, 8'h55);
    acc(0, 1, 8'h10, 8'h00); check("rd10_pre", b0.data_out, 8'h55);
    reset0;
    clear_len(0, -1, n, saw);
    check("clear_len2", n, 248);
    acc(0, 1, 8'h10, 8'h00); check("rd10_post", b0.data_out, 8'h00);
    idle(0);

    acc(0, 0, 8'h20, 8'hA5); check("wr20_ack", b0.ack, 1); check("wr20_err", b0.err, 0);
    acc(0, 1, 8'h20, 8'h00); check("rd20_ack", b0.ack, 1); check("rd20", b0.data_out, 8'hA5);
    acc(0, 1, 8'h21, 8'h00); check("rd21_ack", b0.ack, 1); check("rd21", b0.data_out, 8'h00);
    idle(0); check("ack_drop", b0.ack, 0);

    acc(0, 0, 8'hF8, 8'h3C);
    check("wrf8_ack", b0.ack, 1); check("wrf8_strobe", out_strobe0, 1); check("wrf8_out", outdata0, 8'h3C);
    idle(0); check("strobe_drop", out_strobe0, 0); check("out_hold", outdata0, 8'h3C);
    acc(0, 1, 8'hF8, 8'h00); check("rdf8", b0.data_out, 8'h3C);
    acc(0, 0, 8'h30, 8'h12); check("wr_keeps_dout", b0.data_out, 8'h3C);
    idle(0);

    indata0[7:0] = 8'h11; indata0[31:24] = 8'h44; indata0[55:48] = 8'h77;
    idle(0); idle(0);
    acc(0, 1, 8'hF9, 8'h00); check("rdf9", b0.data_out, 8'h11);
    acc(0, 1, 8'hFF, 8'h00); check("rdff", b0.data_out, 8'h77);
    indata0[7:0] = 8'h22;
    acc(0, 1, 8'hF9, 8'h00); check("rdf9_old", b0.data_out, 8'h11);
    acc(0, 1, 8'hF9, 8'h00); check("rdf9_new", b0.data_out, 8'h22);
    idle(0);

    acc(0, 0, 8'hFC, 8'h99);
    check("ill_ack", b0.ack, 1); check("ill_err", b0.err, 1); check("ill_out", outdata0, 8'h3C);
    acc(0, 1, 8'hFC, 8'h00); check("ill_err_drop", b0.err, 0); check("rdfc", b0.data_out, 8'h44);
    idle(0);

    resetN0 = 1'b0;
    b0.req = 1'b1; b0.readwriteN = 1'b1; b0.address = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst2_out", outdata0, 8'h00); check("rst2_ack", b0.ack, 0);
    resetN0 = 1'b1;
    clear_len(0, 100, n, saw);
    check("mid_reach", n, 100);
    resetN0 = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", b0.busy, 1);
    resetN0 = 1'b1;
    clear_len(0, -1, n, saw);
    b0.req = 1'b0;
    check("mid_clear_len", n, 248);
    check("mid_no_ack", saw, 0);

    resetN1 = 1'b1;
    clear_len(1, -1, n, saw);
    check("s_clear_len", n, 59);
    acc(1, 0, 8'h3C, 8'h5A);
    check("s_wr_strobe", out_strobe1, 3'b010); check("s_wr_out", outdata1, 24'h005A00);
    idle(1); check("s_strobe_drop", out_strobe1, 3'b000);
    acc(1, 1, 8'h3C, 8'h00); check("s_rd3c", b1.data_out, 8'h5A);
    indata1 = 16'hBBAA;
    idle(1); idle(1);
    acc(1, 1, 8'h3E, 8'h00); check("s_rd3e", b1.data_out, 8'hAA);
    acc(1, 1, 8'h3F, 8'h00); check("s_rd3f", b1.data_out, 8'hBB);
    acc(1, 0, 8'h3F, 8'h01); check("s_ill_err", b1.err, 1); check("s_ill_out", outdata1, 24'h005A00);
    acc(1, 0, 8'h3A, 8'h77);
    acc(1, 1, 8'h3A, 8'h00); check("s_rd3a", b1.data_out, 8'h77);
    acc(1, 1, 8'h3B, 8'h00); check("s_rd3b", b1.data_out, 8'h00);
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
